// File: rtl/intersection_pkg.sv
// intersection_pkg
//   Shared types for the intersection scheduler:
//     phase_t     - six signalling phases, 3-bit encoding (also driven on phase_o)
//     dir_t       - approach direction (DIR_NS=0, DIR_EW=1)
//     lamps_t     - the six lamp outputs {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
//     lamp_decode - phase -> lamps
package intersection_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    NS_CLEAR  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    EW_CLEAR  = 3'd5
  } phase_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
  } lamps_t;

  // Exactly one lamp per approach; at most one approach is non-red.
  // Unused encodings fall back to all-red, the safe state.
  function automatic lamps_t lamp_decode(input phase_t p);
    lamps_t l;
    l = 6'b001_001;
    case (p)
      NS_GREEN:  l = 6'b100_001;
      NS_YELLOW: l = 6'b010_001;
      EW_GREEN:  l = 6'b001_100;
      EW_YELLOW: l = 6'b001_010;
      default:   l = 6'b001_001;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer
//   Per-phase cycle counter. Restarts at 0 on the first cycle of each phase
//   and counts up every cycle; while sat_en is high it holds at sat_val.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     clear       - 1 when the phase changes at the next edge (cnt -> 0)
//     sat_en      - enable saturation (green phases)
//     sat_val     - saturation value
//     cnt         - current count
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] sat_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (clear) begin
      cnt_next = '0;
    end else if (sat_en && (cnt_reg >= sat_val)) begin
      cnt_next = cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Demand-actuated two-approach (NS/EW) signal controller with minimum and
//   maximum green, gap-out, all-red clearance, latched demand and emergency
//   preemption.
//   Ports:
//     clk, rst_n            - clock, synchronous active-low reset
//     ns_car_i, ew_car_i    - vehicle presence (level)
//     emg_valid_i           - emergency preemption request (level)
//     emg_dir_i             - preemption direction, 0=NS 1=EW
//     ns_g_o/ns_y_o/ns_r_o  - NS lamps
//     ew_g_o/ew_y_o/ew_r_o  - EW lamps
//     phase_o               - current phase (phase_t encoding)
//     emg_ack_o             - requested direction is currently green
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 40,
  parameter int YELLOW_LEN  = 3,
  parameter int ALL_RED_LEN = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_car_i,
  input  logic       ew_car_i,
  input  logic       emg_valid_i,
  input  logic       emg_dir_i,
  output logic       ns_g_o,
  output logic       ns_y_o,
  output logic       ns_r_o,
  output logic       ew_g_o,
  output logic       ew_y_o,
  output logic       ew_r_o,
  output logic [2:0] phase_o,
  output logic       emg_ack_o
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(ALL_RED_LEN - 1);

  phase_t           phase_reg;
  phase_t           phase_next;
  logic             ns_dem_reg;
  logic             ns_dem_next;
  logic             ew_dem_reg;
  logic             ew_dem_next;
  logic [CNT_W-1:0] cnt;
  lamps_t           lamps;

  dir_t emg_dir;
  logic ns_pre;
  logic ew_pre;
  logic ns_leave;
  logic ew_leave;
  logic is_green;

  assign emg_dir = dir_t'(emg_dir_i);
  assign ns_pre  = emg_valid_i && (emg_dir == DIR_NS);
  assign ew_pre  = emg_valid_i && (emg_dir == DIR_EW);

  // Green exit: opposite preemption at any count, otherwise gap-out or
  // max-out on opposing demand unless own-direction preemption holds green.
  assign ns_leave = ew_pre ||
                    (ew_dem_reg && !ns_pre &&
                     (((cnt >= MIN_LAST) && !ns_car_i) || (cnt == MAX_LAST)));
  assign ew_leave = ns_pre ||
                    (ns_dem_reg && !ew_pre &&
                     (((cnt >= MIN_LAST) && !ew_car_i) || (cnt == MAX_LAST)));

  assign is_green = (phase_reg == NS_GREEN) || (phase_reg == EW_GREEN);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (phase_next != phase_reg),
    .sat_en  (is_green),
    .sat_val (MAX_LAST),
    .cnt     (cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg  <= NS_GREEN;
      ns_dem_reg <= 1'b0;
      ew_dem_reg <= 1'b0;
    end else begin
      phase_reg  <= phase_next;
      ns_dem_reg <= ns_dem_next;
      ew_dem_reg <= ew_dem_next;
    end
  end

  // Next-state logic
  always_comb begin
    phase_next = phase_reg;
    case (phase_reg)
      NS_GREEN:  if (ns_leave)       phase_next = NS_YELLOW;
      NS_YELLOW: if (cnt == Y_LAST)  phase_next = NS_CLEAR;
      NS_CLEAR:  if (cnt == R_LAST)  phase_next = EW_GREEN;
      EW_GREEN:  if (ew_leave)       phase_next = EW_YELLOW;
      EW_YELLOW: if (cnt == Y_LAST)  phase_next = EW_CLEAR;
      EW_CLEAR:  if (cnt == R_LAST)  phase_next = NS_GREEN;
      default:                       phase_next = NS_GREEN;
    endcase

    // Demand latches: set outside own green, cleared on entry to own green
    // (clear is applied last so it wins over a simultaneous set).
    ns_dem_next = ns_dem_reg;
    if ((phase_reg != NS_GREEN) && (ns_car_i || ns_pre)) ns_dem_next = 1'b1;
    if ((phase_next == NS_GREEN) && (phase_reg != NS_GREEN)) ns_dem_next = 1'b0;

    ew_dem_next = ew_dem_reg;
    if ((phase_reg != EW_GREEN) && (ew_car_i || ew_pre)) ew_dem_next = 1'b1;
    if ((phase_next == EW_GREEN) && (phase_reg != EW_GREEN)) ew_dem_next = 1'b0;
  end

  // Output decode: lamps depend on the registered phase only.
  always_comb begin
    lamps     = lamp_decode(phase_reg);
    emg_ack_o = emg_valid_i &&
                (ew_pre ? (phase_reg == EW_GREEN) : (phase_reg == NS_GREEN));
  end

  assign ns_g_o  = lamps.ns_g;
  assign ns_y_o  = lamps.ns_y;
  assign ns_r_o  = lamps.ns_r;
  assign ew_g_o  = lamps.ew_g;
  assign ew_y_o  = lamps.ew_y;
  assign ew_r_o  = lamps.ew_r;
  assign phase_o = phase_reg;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler
//   Directed table-driven bench plus hand-written multi-cycle sequences for
//   the intersection scheduler with default parameters.
module tb_intersection_scheduler;
  import intersection_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_car_i = 1'b0;
  logic       ew_car_i = 1'b0;
  logic       emg_valid_i = 1'b0;
  logic       emg_dir_i = 1'b0;
  logic       ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o;
  logic [2:0] phase_o;
  logic       emg_ack_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic   r;
    logic   n;
    logic   e;
    logic   v;
    logic   d;
    phase_t ph;
    logic   ack;
  } vec_t;

  vec_t tbl[$];

  intersection_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ns_car_i    (ns_car_i),
    .ew_car_i    (ew_car_i),
    .emg_valid_i (emg_valid_i),
    .emg_dir_i   (emg_dir_i),
    .ns_g_o      (ns_g_o),
    .ns_y_o      (ns_y_o),
    .ns_r_o      (ns_r_o),
    .ew_g_o      (ew_g_o),
    .ew_y_o      (ew_y_o),
    .ew_r_o      (ew_r_o),
    .phase_o     (phase_o),
    .emg_ack_o   (emg_ack_o)
  );

  always #5 clk = ~clk;

  // Expected lamps {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} for a phase.
  function automatic logic [5:0] want_lamps(input phase_t p);
    case (p)
      NS_GREEN:  return 6'b100001;
      NS_YELLOW: return 6'b010001;
      NS_CLEAR:  return 6'b001001;
      EW_GREEN:  return 6'b001100;
      EW_YELLOW: return 6'b001010;
      default:   return 6'b001001;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic n, input logic e,
                       input logic v, input logic d);
    rst_n       = r;
    ns_car_i    = n;
    ew_car_i    = e;
    emg_valid_i = v;
    emg_dir_i   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string nm, input phase_t ph, input logic ack);
    chk({nm, "_phase"}, 32'(phase_o), 32'(ph));
    chk({nm, "_lamps"}, 32'({ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o}),
        32'(want_lamps(ph)));
    chk({nm, "_ack"}, 32'(emg_ack_o), 32'(ack));
  endtask

  // Apply one reset edge; check reset-state outputs and latches.
  task automatic reset_dut();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outputs("reset", NS_GREEN, 1'b0);
    chk("reset_cnt", 32'(dut.cnt), 32'd0);
    chk("reset_dem", 32'({dut.ns_dem_reg, dut.ew_dem_reg}), 32'd0);
  endtask

  task automatic add(input logic r, input logic n, input logic e, input logic v,
                     input logic d, input phase_t ph, input logic ack);
    vec_t x;
    x = '{r, n, e, v, d, ph, ack};
    tbl.push_back(x);
  endtask

  initial begin
    phase_t ph;
    logic   v;

    // Table: gap-out after a 1-cycle EW pulse at cycle 2, then a reset row,
    // then preemption toward EW starting at NS_GREEN cnt=4.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NS_GREEN, 1'b0);
    for (int c = 0; c <= 16; c++) begin
      ph = (c < 10) ? NS_GREEN : (c < 13) ? NS_YELLOW : (c < 15) ? NS_CLEAR : EW_GREEN;
      add(1'b1, 1'b0, (c == 2), 1'b0, 1'b0, ph, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EW_GREEN, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      v  = (c >= 4) && (c < 12);
      ph = (c < 5) ? NS_GREEN : (c < 8) ? NS_YELLOW : (c < 10) ? NS_CLEAR : EW_GREEN;
      add(1'b1, 1'b0, 1'b0, v, v, ph, (c >= 10) && (c < 12));
    end

    reset_dut();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].n, tbl[i].e, tbl[i].v, tbl[i].d);
      #1;
      check_outputs($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].ack);
      tick();
    end

    // Rest in green: no cars for 100 cycles.
    reset_dut();
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("rest_c%0d", c),
          32'({phase_o, ns_g_o, ew_r_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o}),
          32'({3'(NS_GREEN), 6'b110000}));
      tick();
    end

    // Max-out: NS car held, EW pulse at cycle 0.
    reset_dut();
    for (int c = 0; c <= 45; c++) begin
      drive(1'b1, 1'b1, (c == 0), 1'b0, 1'b0);
      #1;
      ph = (c < 40) ? NS_GREEN : (c < 43) ? NS_YELLOW : (c < 45) ? NS_CLEAR : EW_GREEN;
      chk($sformatf("maxout_c%0d", c), 32'(phase_o), 32'(ph));
      tick();
    end

    // Own-direction preemption holds NS green past max green.
    reset_dut();
    for (int c = 0; c <= 61; c++) begin
      v = (c < 60);
      drive(1'b1, 1'b0, (c == 0), v, 1'b0);
      #1;
      ph = (c <= 60) ? NS_GREEN : NS_YELLOW;
      chk($sformatf("hold_phase_c%0d", c), 32'(phase_o), 32'(ph));
      chk($sformatf("hold_ack_c%0d", c), 32'(emg_ack_o), 32'(v));
      if (c == 1)  chk("hold_ew_dem", 32'(dut.ew_dem_reg), 32'd1);
      if (c == 45) chk("hold_cnt_sat", 32'(dut.cnt), 32'd39);
      tick();
    end

    // NS preemption raised during NS_CLEAR: the following EW green lasts one
    // cycle. Then reset during EW_YELLOW cnt=1.
    reset_dut();
    for (int c = 0; c <= 17; c++) begin
      v = (c >= 13) && (c <= 16);
      drive((c != 17), 1'b0, (c == 2) || (c == 16), v, 1'b0);
      #1;
      ph = (c < 10) ? NS_GREEN : (c < 13) ? NS_YELLOW : (c < 15) ? NS_CLEAR :
           (c == 15) ? EW_GREEN : EW_YELLOW;
      chk($sformatf("opp_phase_c%0d", c), 32'(phase_o), 32'(ph));
      chk($sformatf("opp_ack_c%0d", c), 32'(emg_ack_o), 32'd0);
      if (c == 14) chk("opp_ew_dem_set", 32'(dut.ew_dem_reg), 32'd1);
      if (c == 15) chk("opp_ew_dem_clr", 32'(dut.ew_dem_reg), 32'd0);
      if (c == 17) begin
        chk("pre_rst_cnt", 32'(dut.cnt), 32'd1);
        chk("pre_rst_dem", 32'({dut.ns_dem_reg, dut.ew_dem_reg}), 32'b11);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outputs("post_rst", NS_GREEN, 1'b0);
    chk("post_rst_cnt", 32'(dut.cnt), 32'd0);
    chk("post_rst_dem", 32'({dut.ns_dem_reg, dut.ew_dem_reg}), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
